// File: rtl/conv1d_mac_sequencer_if.sv
// Control bundle between the conv1d MAC sequencer and its lane.
// Master drives addresses, strobes and the y handshake.
interface conv1d_mac_sequencer_if #(
  parameter int XW = 3,
  parameter int FW = 2,
  parameter int YW = 3
);
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [XW-1:0] addr_x;
  logic [FW-1:0] addr_f;
  logic          enable_mult;
  logic          en_pipeline_reg;
  logic          en_acc;
  logic          acc_first;
  logic          clear_acc;
  logic          clear_reg;
  logic          clear_pipeline_mult;
  logic          y_valid;
  logic          y_ready;
  logic [YW-1:0] y_idx;
  logic          busy;
  logic          done;

  modport master (
    input  start, abort, y_ready,
    output rd_en, addr_x, addr_f,
    output enable_mult, en_pipeline_reg,
    output en_acc, acc_first,
    output clear_acc, clear_reg,
    output clear_pipeline_mult,
    output y_valid, y_idx, busy, done
  );

  modport slave (
    output start, abort, y_ready,
    input  rd_en, addr_x, addr_f,
    input  enable_mult, en_pipeline_reg,
    input  en_acc, acc_first,
    input  clear_acc, clear_reg,
    input  clear_pipeline_mult,
    input  y_valid, y_idx, busy, done
  );
endinterface

// File: rtl/conv1d_mac_sequencer.sv
// Sequencer for one pipelined MAC lane of the 1D convolution engine.
// Issues x/f reads and tracks each term with a tag pipe to drive strobes.
module conv1d_mac_sequencer #(
  parameter int N           = 8,
  parameter int M           = 4,
  parameter int MULT_STAGES = 2,
  parameter int XW = (N > 1) ? $clog2(N) : 1,
  parameter int FW = (M > 1) ? $clog2(M) : 1,
  parameter int YW = (N - M + 1 > 1) ? $clog2(N - M + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  conv1d_mac_sequencer_if.master bus
);
  localparam int L = MULT_STAGES - 1;
  localparam int F = L + 2;
  localparam int D = L + 3;

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [YW-1:0] i_q;
  logic [YW-1:0] y_idx_q;
  logic [FW-1:0] j_q;
  logic [D:1]    v_q;
  logic [D:1]    l_q;
  logic [F:1]    f_q;

  logic y_vld, stall, hs;
  logic kick, flush, issue;
  logic last_j, last_term, last_hs;

  assign y_vld = v_q[D] & l_q[D];
  assign stall = y_vld & ~bus.y_ready;
  assign hs    = y_vld & bus.y_ready;

  assign kick  = (state == IDLE) & bus.start & ~bus.abort;
  assign flush = kick | ((state != IDLE) & bus.abort);
  assign issue = (state == RUN) & ~stall & ~bus.abort;

  assign last_j    = (j_q == FW'(M - 1));
  assign last_term = last_j & (i_q == YW'(N - M));
  assign last_hs   = hs & (y_idx_q == YW'(N - M))
                   & (state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (kick) state_nx = RUN;
      RUN:   if (issue && last_term) state_nx = DRAIN;
      DRAIN: if (last_hs) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && bus.abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      y_idx_q <= '0;
    end else if (flush) begin
      i_q     <= '0;
      j_q     <= '0;
      y_idx_q <= '0;
    end else begin
      if (issue) begin
        if (last_j) begin
          j_q <= '0;
          i_q <= last_term ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if (hs) begin
        if (y_idx_q == YW'(N - M)) y_idx_q <= '0;
        else                       y_idx_q <= y_idx_q + 1'b1;
      end
    end
  end

  // Whole tag pipe freezes under back-pressure so the acc keeps y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      l_q <= '0;
      f_q <= '0;
    end else if (flush) begin
      v_q <= '0;
      l_q <= '0;
      f_q <= '0;
    end else if (!stall) begin
      v_q <= {v_q[D-1:1], issue};
      l_q <= {l_q[D-1:1], last_j};
      f_q <= {f_q[F-1:1], j_q == '0};
    end
  end

  assign bus.rd_en  = issue;
  assign bus.addr_x = issue ? XW'(i_q) + XW'(j_q) : '0;
  assign bus.addr_f = issue ? j_q : '0;

  assign bus.enable_mult     = v_q[1] & ~stall;
  assign bus.en_pipeline_reg = v_q[1+L] & ~stall;
  assign bus.en_acc          = v_q[F] & ~stall;
  assign bus.acc_first       = v_q[F] & ~stall & f_q[F];

  assign bus.clear_acc           = flush;
  assign bus.clear_reg           = flush;
  assign bus.clear_pipeline_mult = flush;

  assign bus.y_valid = y_vld;
  assign bus.y_idx   = y_idx_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_conv1d_mac_sequencer.sv
// Bench for conv1d_mac_sequencer: cycle vectors, MAC model scoreboard,
// corner sequences and two alternate parameterisations.
module tb_conv1d_mac_sequencer;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv1d_mac_sequencer_if #(.XW(3), .FW(2), .YW(3)) sif ();
  conv1d_mac_sequencer_if #(.XW(3), .FW(2), .YW(3)) sif2 ();
  conv1d_mac_sequencer_if #(.XW(2), .FW(2), .YW(1)) sif3 ();

  conv1d_mac_sequencer #(.N(8), .M(4), .MULT_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(sif)
  );
  conv1d_mac_sequencer #(.N(8), .M(4), .MULT_STAGES(1)) dut2 (
    .clk(clk), .reset(reset), .bus(sif2)
  );
  conv1d_mac_sequencer #(.N(4), .M(4), .MULT_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .bus(sif3)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Lane datapath model: buffers, multiplier, pipe reg, accumulator.
  logic [7:0]  xm [N];
  logic [7:0]  fm [M];
  logic [7:0]  bx, bf;
  logic [15:0] mreg, preg;
  logic [19:0] acc;

  typedef struct packed {
    logic [2:0]  idx;
    logic [19:0] y;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int hs_cnt, done_cnt;

  function automatic void push_all();
    logic [19:0] s;
    for (int i = 0; i <= N - M; i++) begin
      s = '0;
      for (int j = 0; j < M; j++) s += xm[i+j] * fm[j];
      sbq.push_back('{idx: 3'(i), y: s});
    end
  endfunction

  always @(posedge clk) begin
    if (sif.rd_en) begin
      bx <= xm[sif.addr_x];
      bf <= fm[sif.addr_f];
    end
    if (sif.clear_pipeline_mult) mreg <= '0;
    else if (sif.enable_mult)    mreg <= bx * bf;
    if (sif.clear_reg)            preg <= '0;
    else if (sif.en_pipeline_reg) preg <= mreg;
    if (sif.clear_acc)   acc <= '0;
    else if (sif.en_acc)
      acc <= sif.acc_first ? 20'(preg) : acc + 20'(preg);
    if (reset && sif.y_valid && sif.y_ready) begin
      hs_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("y_idx", sif.y_idx, e.idx);
        chk("y_value", acc, e.y);
      end
    end
    if (sif.done) done_cnt++;
    if (reset && !sif.busy && sif.start && !sif.abort)
      push_all();
    if (sif.busy && sif.abort) sbq.delete();
  end

  function automatic logic [15:0] obs();
    return {sif.rd_en, sif.addr_x, sif.addr_f,
            sif.enable_mult, sif.en_acc, sif.acc_first,
            sif.y_valid, sif.y_idx, sif.done, sif.busy,
            sif.clear_acc};
  endfunction

  typedef struct {
    int          cyc;
    logic [15:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c, bit rd, int ax, int af,
                              bit em, bit ea, bit a1, bit yv,
                              int yi, bit dn, bit bz, bit cl);
    vec_t v;
    v.cyc = c;
    v.o = {rd, 3'(ax), 2'(af), em, ea, a1, yv, 3'(yi),
           dn, bz, cl};
    return v;
  endfunction

  logic [15:0] ob   [64];
  logic        enpr [64];
  logic [2:0]  clr  [64];
  logic [19:0] accr [64];

  task automatic run_main(int ncyc, int st_a, int st_b,
                          int rlo, int rhi, int ab, bit tbl_on);
    hs_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      sif.start = (c == 0) || (c == st_a) || (c == st_b);
      sif.y_ready = !(c >= rlo && c <= rhi);
      sif.abort = (c == ab);
      @(negedge clk);
      ob[c] = obs();
      enpr[c] = sif.en_pipeline_reg;
      clr[c] = {sif.clear_acc, sif.clear_reg,
                sif.clear_pipeline_mult};
      accr[c] = acc;
      if (tbl_on)
        foreach (tbl[k])
          if (tbl[k].cyc == c)
            chk($sformatf("vec_c%0d", c), ob[c], tbl[k].o);
      @(posedge clk);
      #1;
    end
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.y_ready = 1'b1;
  endtask

  int yv_cnt, first2, hs2, hs3, hs3c, dn3c;

  initial begin
    sif.start = 0;  sif.abort = 0;  sif.y_ready = 1;
    sif2.start = 0; sif2.abort = 0; sif2.y_ready = 1;
    sif3.start = 0; sif3.abort = 0; sif3.y_ready = 1;
    for (int k = 0; k < N; k++) xm[k] = 8'(k + 1);
    for (int k = 0; k < M; k++) fm[k] = 8'd1;

    tbl.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 4, 1, 3, 3, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 5, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk( 8, 1, 4, 3, 1, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(12, 1, 5, 3, 1, 1, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(21, 0, 0, 0, 1, 1, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(24, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 0));
    tbl.push_back(mk(25, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(26, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    #1;
    chk("reset_outputs", obs(), 0);
    chk("reset_clears", {sif.clear_reg, sif.en_pipeline_reg}, 0);
    #12 reset = 1'b1;
    @(posedge clk);
    #1;

    // Nominal run with unconditional y_ready.
    run_main(30, -1, -1, -1, -1, -1, 1'b1);
    chk("s1_outputs", hs_cnt, 5);
    chk("s1_done", done_cnt, 1);
    chk("s1_queue_empty", sbq.size(), 0);

    // Back-pressure on the first output.
    run_main(34, -1, -1, 8, 10, -1, 1'b0);
    chk("s2_hold_valid", ob[9][6], 1);
    chk("s2_hold_idx", ob[9][5:3], 0);
    chk("s2_hold_enables",
        {ob[9][15], ob[9][9], ob[9][8], enpr[9]}, 0);
    chk("s2_hold_acc", accr[9], 10);
    chk("s2_hold_acc_end", accr[10], 10);
    chk("s2_done_cycle", {ob[27][2], ob[28][2]}, 2'b01);
    chk("s2_outputs", hs_cnt, 5);
    chk("s2_queue_empty", sbq.size(), 0);

    // Abort mid-run, then a clean restart.
    run_main(30, -1, -1, -1, -1, 13, 1'b0);
    chk("s3_clears", clr[13], 3'b111);
    chk("s3_busy_abort", ob[13][1], 1);
    chk("s3_idle_after", ob[14][1], 0);
    yv_cnt = 0;
    for (int c = 14; c < 30; c++) yv_cnt += int'(ob[c][6]);
    chk("s3_no_valid", yv_cnt, 0);
    chk("s3_no_done", done_cnt, 0);
    run_main(30, -1, -1, -1, -1, -1, 1'b1);
    chk("s3_restart_outputs", hs_cnt, 5);

    // start and abort in the same idle cycle.
    sif.start = 1; sif.abort = 1;
    @(negedge clk);
    chk("sa_no_clear", sif.clear_acc, 0);
    @(posedge clk);
    #1;
    sif.start = 0; sif.abort = 0;
    @(negedge clk);
    chk("sa_stay_idle", sif.busy, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a run.
    sif.start = 1;
    @(posedge clk);
    #1;
    sif.start = 0;
    repeat (8) @(posedge clk);
    #2;
    chk("rst_busy_before", sif.busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_outputs", obs(), 0);
    chk("rst_async_misc",
        {sif.en_pipeline_reg, sif.clear_reg,
         sif.clear_pipeline_mult}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("rst_idle_after", {sif.busy, sif.y_valid}, 0);
    @(posedge clk);
    #1;

    // start pulses while busy are ignored.
    run_main(30, 5, 15, -1, -1, -1, 1'b0);
    chk("s4_outputs", hs_cnt, 5);
    chk("s4_done", done_cnt, 1);
    chk("s4_queue_empty", sbq.size(), 0);

    // Random data and random back-pressure.
    for (int k = 0; k < N; k++) xm[k] = 8'($urandom_range(0, 15));
    for (int k = 0; k < M; k++) fm[k] = 8'($urandom_range(0, 15));
    hs_cnt = 0;
    done_cnt = 0;
    sif.start = 1;
    for (int c = 0; c < 300 && done_cnt == 0; c++) begin
      @(posedge clk);
      #1;
      sif.start = 0;
      sif.y_ready = ($urandom_range(0, 3) != 0);
    end
    sif.y_ready = 1;
    chk("rand_done", done_cnt, 1);
    chk("rand_outputs", hs_cnt, 5);
    chk("rand_queue_empty", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // L=0 lane and the M==N lane side by side.
    first2 = -1; hs2 = 0; hs3 = 0; hs3c = -1; dn3c = -1;
    sif2.start = 1;
    sif3.start = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sif2.y_valid && first2 < 0) first2 = c;
      if (sif2.y_valid && sif2.y_ready) hs2++;
      if (sif3.y_valid && sif3.y_ready) begin
        hs3++;
        hs3c = c;
        chk("mn_y_idx", sif3.y_idx, 0);
      end
      if (sif3.done) dn3c = c;
      @(posedge clk);
      #1;
      sif2.start = 0;
      sif3.start = 0;
    end
    chk("l0_first_valid", first2, 7);
    chk("l0_outputs", hs2, 5);
    chk("mn_outputs", hs3, 1);
    chk("mn_valid_cycle", hs3c, 8);
    chk("mn_done_cycle", dn3c, hs3c + 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
